mux_scan_sequencer: RTL
=======================

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 SHALL have parameter SETTLE, default 0, meaning extra wait cycles per channel before sampling; legal range 0..255.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  scan request, sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  synchronous scan cancel.
REQ-006 SHALL have port f_in  input  1  selected bit returned by the downstream 16:1 mux.
REQ-007 SHALL have port sel  output  4  channel select driven to the 16:1 mux.
REQ-008 SHALL have port busy  output  1  high while scanning (WAIT or SAMP).
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port data_out  output  16  assembled word; bit k = f_in sampled with sel=k.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, SAMP, DONE.
REQ-012 IDLE: sel=0, busy=0, done=0; start=1 and abort=0 at clk edge -> WAIT if SETTLE>0, else SAMP; sel=0.
REQ-013 WAIT: 8-bit counter counts SETTLE cycles with sel held; after the SETTLE-th cycle -> SAMP.
REQ-014 SAMP: lasts one cycle; captures f_in into bit sel of internal shadow word at the edge.
REQ-015 SAMP with sel<15: sel increments by 1; next state WAIT (SETTLE>0) or SAMP (SETTLE=0).
REQ-016 SAMP with sel=15: shadow word, including this bit, loads data_out; next state DONE; sel holds 15.
REQ-017 DONE: done=1 and busy=0 for exactly one cycle; next state IDLE; sel returns to 0 on entry to IDLE.
REQ-018 Each channel SHALL be held on sel for exactly SETTLE+1 cycles; busy SHALL be high for exactly 16*(SETTLE+1) cycles.
REQ-019 done SHALL be high in the cycle that begins 16*(SETTLE+1)+1 edges after the start edge; data_out SHALL be valid in that cycle.
REQ-020 data_out SHALL hold its value until the next completed scan; it SHALL be unchanged by aborted scans.
REQ-021 start while in WAIT, SAMP or DONE SHALL be ignored; it is not queued.
REQ-022 abort=1 in WAIT, SAMP or DONE -> IDLE at next edge; no done pulse; sel=0; shadow word discarded.
REQ-023 start=1 and abort=1 together in IDLE: abort wins; state remains IDLE.
REQ-024 Counter SHALL reload to 0 on every entry to WAIT; no wrap occurs for legal SETTLE.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, sel=0, busy=0, done=0, data_out=16'h0000, counter=0, shadow=0, regardless of clk.
REQ-026 Reset mid-scan SHALL discard the scan with no done pulse; first start after rst_n deasserts begins a fresh scan at channel 0.

Configuration
REQ-027 Macro SCAN_CONT_EN, when defined, SHALL add input port cont (1 bit); in DONE with cont=1 and abort=0, next state SHALL be WAIT/SAMP with sel=0 (continuous scan, busy low only during DONE); cont=0 behaves as REQ-017.
REQ-028 Without SCAN_CONT_EN, port cont SHALL NOT exist and DONE SHALL always return to IDLE.

Verification
REQ-029 SETTLE=0, mux model on pattern 16'hA5C3, start pulse -> sel steps 0..15 one per cycle, done 17 edges after start, data_out=16'hA5C3.
REQ-030 SETTLE=3, pattern 16'h0F0F -> each sel value held 4 cycles, busy high 64 cycles, done at edge 65, data_out=16'h0F0F.
REQ-031 Complete scan of 16'h1234, then new scan of 16'hFFFF aborted while sel=7 -> no done pulse, sel=0 next cycle, data_out stays 16'h1234.
REQ-032 start re-pulsed at sel=5 and during DONE -> ignored; exactly one done pulse; data_out matches pattern.
REQ-033 rst_n low asynchronously at sel=9 -> outputs reset without clk edge; later start scans 16'h8001 correctly.
REQ-034 SCAN_CONT_EN defined, cont=1, SETTLE=0, pattern changed 16'hAAAA->16'h5555 between scans -> done every 17 cycles, data_out 16'hAAAA then 16'h5555, no IDLE cycle.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Walks a 16:1 mux through channels 0..15 and assembles the returned bits into data_out.
// Optional continuous rescan is enabled by defining SCAN_CONT_EN, which adds input cont.
module mux_scan_sequencer #(
    parameter int SETTLE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        f_in,
`ifdef SCAN_CONT_EN
    input  logic        cont,
`endif
    output logic [3:0]  sel,
    output logic        busy,
    output logic        done,
    output logic [15:0] data_out
);

    typedef enum logic [1:0] {IDLE, WAIT, SAMP, DONE} state_t;

    // With no settle time the sequencer skips WAIT and samples every cycle.
    localparam state_t         SCAN_ENTRY = (SETTLE > 0) ? WAIT : SAMP;
    localparam logic [7:0]     SETTLE_LAST = 8'(SETTLE - 1);

    state_t      state, state_n;
    logic [3:0]  sel_n;
    logic [7:0]  cnt, cnt_n;
    logic [15:0] shadow, shadow_n;
    logic [15:0] data_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 4'd0;
            cnt      <= 8'd0;
            shadow   <= 16'h0000;
            data_out <= 16'h0000;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            cnt      <= cnt_n;
            shadow   <= shadow_n;
            data_out <= data_n;
        end
    end

    always_comb begin
        state_n  = state;
        sel_n    = sel;
        cnt_n    = cnt;
        shadow_n = shadow;
        data_n   = data_out;
        case (state)
            IDLE: begin
                sel_n = 4'd0;
                if (start && !abort) begin
                    state_n  = SCAN_ENTRY;
                    cnt_n    = 8'd0;
                    shadow_n = 16'h0000;
                end
            end
            WAIT: begin
                if (cnt == SETTLE_LAST) begin
                    state_n = SAMP;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            SAMP: begin
                shadow_n[sel] = f_in;
                if (sel == 4'd15) begin
                    data_n  = shadow_n;
                    state_n = DONE;
                end else begin
                    sel_n   = sel + 4'd1;
                    cnt_n   = 8'd0;
                    state_n = SCAN_ENTRY;
                end
            end
            DONE: begin
                sel_n   = 4'd0;
                state_n = IDLE;
`ifdef SCAN_CONT_EN
                if (cont) begin
                    state_n  = SCAN_ENTRY;
                    cnt_n    = 8'd0;
                    shadow_n = 16'h0000;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
        // Abort overrides everything outside IDLE; a partial word never reaches data_out.
        if (abort && state != IDLE) begin
            state_n  = IDLE;
            sel_n    = 4'd0;
            cnt_n    = 8'd0;
            shadow_n = 16'h0000;
            data_n   = data_out;
        end
    end

    assign busy = (state == WAIT) || (state == SAMP);
    assign done = (state == DONE);

endmodule
